exception_unit: RTL
===================

Name: exception_unit

Overview:
- Parametrised, sequential successor to the write-back-stage exception logic in the MIPS32 core.
- Collects synchronous exception requests from the committing instruction. Synchronises a configurable number of hardware interrupt lines and prioritises all sources.
- Runs a small FSM that flushes the pipeline and redirects fetch to the exception vector or to EPC (ERET).
- Sits beside CP0 in WB and drives CP0 register write-enables and values.

Parameters:
- HW_IRQ_NUM, 6, number of hardware interrupt lines (1..6); they map to Cause.IP[2+HW_IRQ_NUM-1:2], and unused IP bits read 0.
- SYNC_STAGES, 2, flip-flop stages on each hw_irq line (1..3).
- EXC_VECTOR, 32'hBFC00380, redirect target for all exceptions and interrupts.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- commit_valid  in  1  an instruction is committing in WB this cycle
- commit_pc  in  32  PC of the committing instruction
- commit_is_ds  in  1  committing instruction is in a branch delay slot
- commit_eret  in  1  committing instruction is ERET
- exc_req  in  7  [0] fetch AdEL, [1] RI, [2] Ov, [3] Sys, [4] Bp, [5] load AdEL, [6] store AdES
- mem_badvaddr  in  32  data address for exc_req[6:5]
- hw_irq  in  HW_IRQ_NUM  asynchronous interrupt lines, level
- sw_irq  in  2  Cause.IP[1:0]
- status_ie, status_exl  in  1 each  current Status bits
- status_im  in  8  Status.IM
- epc_in  in  32  current EPC
- stall_w, flush_w  in  1 each  WB stall / flush
- timer_cmp_we  in  1  write to Compare (used only with TIMER_IRQ_EN)
- timer_cmp_wdata  in  32  Compare write data
- cause_ip  out  8  synchronised pending IP vector
- exc_we  out  1  one-cycle CP0 update strobe (EPC, Cause.ExcCode/BD, Status.EXL set)
- exc_code  out  5  ExcCode
- exc_epc  out  32  EPC value
- exc_bd  out  1  Cause.BD
- badvaddr_we  out  1  BadVAddr write strobe
- badvaddr  out  32  BadVAddr value
- eret_we  out  1  clear Status.EXL strobe
- flush_req  out  1  flush IF..WB
- redirect_valid  out  1  fetch redirect strobe
- redirect_pc  out  32  redirect target
- timer_irq  out  1  timer interrupt pending (0 without TIMER_IRQ_EN)

Behaviour:
- Reset: FSM=IDLE, sync chains 0, all outputs 0, holding registers 0.
- cause_ip = {sync(hw_irq) zero-extended to 6 bits, sw_irq}.
- Interrupts:
  - irq_take = |(cause_ip & status_im) & status_ie & !status_exl.
  - An interrupt is taken only in a cycle with commit_valid. The committing instruction is not committed; EPC is computed for it.
- Evaluation cycle: commit_valid & !stall_w & !flush_w & state==IDLE.
- Priority, highest first: interrupt (code 0), fetch AdEL (4), RI (10), Ov (12), Sys (8), Bp (9), load AdEL (4), store AdES (5).
- Any exception or interrupt is ignored when status_exl=1, except that ERET still executes.
- EPC = commit_is_ds ? commit_pc-4 : commit_pc; exc_bd = commit_is_ds.
- BadVAddr:
  - fetch AdEL: badvaddr = commit_pc.
  - load/store address error: badvaddr = mem_badvaddr.
  - badvaddr_we is set only for these codes.
- ERET with epc_in[1:0]!=0: raise AdEL with badvaddr = epc_in and EPC = epc_in; eret_we stays 0.
- ERET with aligned epc_in: eret_we=1 and target = epc_in.
- FSM:
  - IDLE -> TRAP on exception/interrupt detection. Cause data is latched at this edge.
  - IDLE -> RET on valid ERET.
  - TRAP (1 cycle): exc_we=1, badvaddr_we as latched, flush_req=1 -> REDIR.
  - RET (1 cycle): eret_we=1, flush_req=1 -> REDIR.
  - REDIR (1 cycle): redirect_valid=1, redirect_pc = EXC_VECTOR or latched epc_in -> IDLE.
  - Latency from detection to the CP0 strobe is 1 cycle; to redirect, 2 cycles.
- New commits during TRAP/RET/REDIR are ignored; upstream is already flushed.
- Simultaneous exception and ERET on the same instruction: the exception wins.
- rst mid-sequence returns to IDLE immediately with all strobes 0.

Optional Feature:
- Macro TIMER_IRQ_EN.
- When defined:
  - A 32-bit Count register increments every second clk, wrapping at 2^32.
  - Compare is written by timer_cmp_we; this write also clears timer_irq.
  - timer_irq is set when Count==Compare and stays set until the next Compare write.
  - timer_irq is ORed into cause_ip[7].
- When not defined: no Count/Compare registers, timer_irq=0, and the timer_cmp ports are ignored.

Test Plan:
- Sys at commit_pc=0x80001000, is_ds=0, exl=0 -> next cycle exc_we=1, exc_code=8, exc_epc=0x80001000, flush_req=1; following cycle redirect_valid=1, redirect_pc=0xBFC00380.
- Store AdES plus Ov together, commit_pc=0x80002004, is_ds=1, mem_badvaddr=0x1003 -> exc_code=12, exc_epc=0x80002000, exc_bd=1, badvaddr_we=0.
- hw_irq[0] held, im=0x04, ie=1, commit_valid -> after SYNC_STAGES cycles cause_ip=0x04; next commit at 0x80003000 gives exc_code=0 and exc_epc=0x80003000.
- ERET with epc_in=0x80004002 -> exc_code=4, badvaddr=0x80004002, eret_we=0, redirect to 0xBFC00380. With epc_in=0x80004000 -> eret_we=1, redirect_pc=0x80004000.
- status_exl=1 with RI asserted -> no strobes; assert rst during TRAP -> all outputs 0 on the next cycle.
- TIMER_IRQ_EN defined, Compare=10 -> timer_irq=1 about 20 cycles after reset; a Compare write clears it.

Source files
------------

// File: rtl/exception_unit.sv
// Write-back exception unit: prioritises synchronous exceptions and synchronised interrupts,
// then flushes the pipeline and redirects fetch. Optional Count/Compare timer via TIMER_IRQ_EN.
module exception_unit #(
  parameter int          HW_IRQ_NUM  = 6,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_valid,
  input  logic [31:0]           commit_pc,
  input  logic                  commit_is_ds,
  input  logic                  commit_eret,
  input  logic [6:0]            exc_req,
  input  logic [31:0]           mem_badvaddr,
  input  logic [HW_IRQ_NUM-1:0] hw_irq,
  input  logic [1:0]            sw_irq,
  input  logic                  status_ie,
  input  logic                  status_exl,
  input  logic [7:0]            status_im,
  input  logic [31:0]           epc_in,
  input  logic                  stall_w,
  input  logic                  flush_w,
  input  logic                  timer_cmp_we,
  input  logic [31:0]           timer_cmp_wdata,
  output logic [7:0]            cause_ip,
  output logic                  exc_we,
  output logic [4:0]            exc_code,
  output logic [31:0]           exc_epc,
  output logic                  exc_bd,
  output logic                  badvaddr_we,
  output logic [31:0]           badvaddr,
  output logic                  eret_we,
  output logic                  flush_req,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic                  timer_irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAP  = 2'd1,
    ST_RET   = 2'd2,
    ST_REDIR = 2'd3
  } state_t;

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_BP   = 5'd9;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_OV   = 5'd12;

  state_t        r_state;
  state_t        w_state_next;

  logic [4:0]    r_exc_code;
  logic [31:0]   r_exc_epc;
  logic          r_exc_bd;
  logic          r_badvaddr_we;
  logic [31:0]   r_badvaddr;
  logic [31:0]   r_target;

  logic [HW_IRQ_NUM-1:0] w_hw_sync;
  logic [5:0]    w_ip_hw;
  logic [7:0]    w_cause_ip;
  logic          w_timer_irq;
  logic          w_irq_take;
  logic          w_eval;
  logic [6:0]    w_exc_req;
  logic          w_eret_bad;
  logic [31:0]   w_epc_commit;
  logic          w_trap;
  logic [4:0]    w_code;
  logic [31:0]   w_epc;
  logic          w_bd;
  logic          w_bv_we;
  logic [31:0]   w_bv;
  logic          w_go_trap;
  logic          w_go_ret;

  // Per-line synchroniser; the last stage feeds Cause.IP.
  genvar gi;
  generate
    for (gi = 0; gi < HW_IRQ_NUM; gi++) begin : g_irq_sync
      logic [SYNC_STAGES-1:0] r_chain;
      if (SYNC_STAGES == 1) begin : g_single
        always_ff @(posedge clk) begin
          if (rst) r_chain <= '0;
          else     r_chain <= hw_irq[gi];
        end
      end else begin : g_multi
        always_ff @(posedge clk) begin
          if (rst) r_chain <= '0;
          else     r_chain <= {r_chain[SYNC_STAGES-2:0], hw_irq[gi]};
        end
      end
      assign w_hw_sync[gi] = r_chain[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    w_ip_hw = '0;
    w_ip_hw[HW_IRQ_NUM-1:0] = w_hw_sync;
  end

`ifdef TIMER_IRQ_EN
  logic        r_count_tick;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_timer_irq;

  // Count advances on every second clock; a Compare write takes precedence over a match.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count_tick <= 1'b0;
      r_count      <= '0;
      r_compare    <= '0;
      r_timer_irq  <= 1'b0;
    end else begin
      r_count_tick <= ~r_count_tick;
      if (r_count_tick) r_count <= r_count + 32'd1;
      if (timer_cmp_we) begin
        r_compare   <= timer_cmp_wdata;
        r_timer_irq <= 1'b0;
      end else if (r_count == r_compare) begin
        r_timer_irq <= 1'b1;
      end
    end
  end

  assign w_timer_irq = r_timer_irq;
`else
  logic w_unused_timer;
  assign w_unused_timer = ^{timer_cmp_we, timer_cmp_wdata};
  assign w_timer_irq    = 1'b0;
`endif

  assign w_cause_ip   = {w_ip_hw[5] | w_timer_irq, w_ip_hw[4:0], sw_irq};
  assign w_irq_take   = (|(w_cause_ip & status_im)) & status_ie & ~status_exl;
  assign w_eval       = commit_valid & ~stall_w & ~flush_w & (r_state == ST_IDLE);
  assign w_exc_req    = status_exl ? 7'd0 : exc_req;
  assign w_eret_bad   = commit_eret & (epc_in[1:0] != 2'b00);
  assign w_epc_commit = commit_is_ds ? (commit_pc - 32'd4) : commit_pc;

  // Priority encoder; a misaligned ERET target becomes an AdEL on the ERET itself.
  always_comb begin
    w_trap  = 1'b1;
    w_code  = CODE_INT;
    w_epc   = w_epc_commit;
    w_bd    = commit_is_ds;
    w_bv_we = 1'b0;
    w_bv    = '0;
    if (w_irq_take) begin
      w_code = CODE_INT;
    end else if (w_exc_req[0]) begin
      w_code  = CODE_ADEL;
      w_bv_we = 1'b1;
      w_bv    = commit_pc;
    end else if (w_exc_req[1]) begin
      w_code = CODE_RI;
    end else if (w_exc_req[2]) begin
      w_code = CODE_OV;
    end else if (w_exc_req[3]) begin
      w_code = CODE_SYS;
    end else if (w_exc_req[4]) begin
      w_code = CODE_BP;
    end else if (w_exc_req[5]) begin
      w_code  = CODE_ADEL;
      w_bv_we = 1'b1;
      w_bv    = mem_badvaddr;
    end else if (w_exc_req[6]) begin
      w_code  = CODE_ADES;
      w_bv_we = 1'b1;
      w_bv    = mem_badvaddr;
    end else if (w_eret_bad) begin
      w_code  = CODE_ADEL;
      w_epc   = epc_in;
      w_bd    = 1'b0;
      w_bv_we = 1'b1;
      w_bv    = epc_in;
    end else begin
      w_trap = 1'b0;
    end
  end

  assign w_go_trap = w_eval & w_trap;
  assign w_go_ret  = w_eval & ~w_trap & commit_eret;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Cause data is captured on the detection edge and held through TRAP/RET/REDIR.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exc_code    <= '0;
      r_exc_epc     <= '0;
      r_exc_bd      <= 1'b0;
      r_badvaddr_we <= 1'b0;
      r_badvaddr    <= '0;
      r_target      <= '0;
    end else if (w_go_trap) begin
      r_exc_code    <= w_code;
      r_exc_epc     <= w_epc;
      r_exc_bd      <= w_bd;
      r_badvaddr_we <= w_bv_we;
      r_badvaddr    <= w_bv;
      r_target      <= EXC_VECTOR;
    end else if (w_go_ret) begin
      r_target      <= epc_in;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    exc_we         = 1'b0;
    badvaddr_we    = 1'b0;
    eret_we        = 1'b0;
    flush_req      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_go_trap)     w_state_next = ST_TRAP;
        else if (w_go_ret) w_state_next = ST_RET;
      end
      ST_TRAP: begin
        exc_we       = 1'b1;
        badvaddr_we  = r_badvaddr_we;
        flush_req    = 1'b1;
        w_state_next = ST_REDIR;
      end
      ST_RET: begin
        eret_we      = 1'b1;
        flush_req    = 1'b1;
        w_state_next = ST_REDIR;
      end
      ST_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = r_target;
        w_state_next   = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign cause_ip  = w_cause_ip;
  assign exc_code  = r_exc_code;
  assign exc_epc   = r_exc_epc;
  assign exc_bd    = r_exc_bd;
  assign badvaddr  = r_badvaddr;
  assign timer_irq = w_timer_irq;

endmodule
